mux_tree_pipe: RTL

//  Parametrised, pipelined N:1 multiplexer tree with valid/ready handshake on both sides.

---
 rtl/mux_tree_pkg.sv | 26 ++
 rtl/mux_tree_pipe_if.sv | 30 +++
 rtl/mux_tree_stage.sv | 93 +++++++++
 rtl/mux_tree_pipe.sv | 98 +++++++++
 4 files changed

// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined mux tree.
package mux_tree_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_NUM_IN    = 4;
  localparam int unsigned DEF_CONST_VAL = (1 << 2) + 1;

  // Ceiling log2, usable in parameter expressions
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // True when v is a power of two and at least 2
  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Input and output handshake bundle of the mux tree.
interface mux_tree_pipe_if #(
  parameter int unsigned WIDTH  = mux_tree_pkg::DEF_WIDTH,
  parameter int unsigned NUM_IN = mux_tree_pkg::DEF_NUM_IN
);

  localparam int unsigned SEL_W = mux_tree_pkg::clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  // Source of input beats and sink of output beats
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  // The mux tree itself
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/mux_tree_stage.sv
// One tree level: halves the candidate set on the low select bit and registers the result.
module mux_tree_stage
  import mux_tree_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned N_IN        = DEF_NUM_IN,
  parameter int unsigned SEL_W       = 2,
  parameter bit          RST_PAYLOAD = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IN*WIDTH-1:0]      in_data_i,
  input  logic [SEL_W-1:0]           in_sel_i,
  input  logic [SEL_W-1:0]           in_orig_i,
  input  logic                       in_valid_i,
  input  logic                       load_ok_i,
  output logic [(N_IN/2)*WIDTH-1:0]  out_data_o,
  output logic [SEL_W-1:0]           out_sel_o,
  output logic [SEL_W-1:0]           out_orig_o,
  output logic                       out_valid_o
);

  localparam int unsigned N_OUT = N_IN / 2;
  localparam int unsigned OUT_W = N_OUT * WIDTH;

  logic [OUT_W-1:0] red_c;
  logic [OUT_W-1:0] data_d, data_q;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic [SEL_W-1:0] orig_d, orig_q;
  logic             valid_d, valid_q;

  // Pairwise 2:1 reduction steered by the lowest remaining select bit
  always_comb begin
    red_c = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      red_c[i*WIDTH +: WIDTH] = in_sel_i[0] ? in_data_i[(2*i+1)*WIDTH +: WIDTH]
                                            : in_data_i[(2*i)*WIDTH +: WIDTH];
    end
  end

  // Load a beat when permitted (stage empty or its beat leaves), else hold everything
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    orig_d  = orig_q;
    valid_d = valid_q;
    if (load_ok_i) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = red_c;
        sel_d  = in_sel_i >> 1;
        orig_d = in_orig_i;
      end
    end
  end

  // Occupancy flag is always cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  if (RST_PAYLOAD) begin : g_rst_payload
    // Payload with reset: used where the register is visible at the block output
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        sel_q  <= '0;
        orig_q <= '0;
      end else begin
        data_q <= data_d;
        sel_q  <= sel_d;
        orig_q <= orig_d;
      end
    end
  end else begin : g_nrst_payload
    // Internal payload only matters while its valid bit is set
    always_ff @(posedge clk) begin
      data_q <= data_d;
      sel_q  <= sel_d;
      orig_q <= orig_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_sel_o   = sel_q;
  assign out_orig_o  = orig_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree, one register level per select bit, with valid/ready backpressure.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned NUM_IN    = DEF_NUM_IN,
  parameter bit          CONST_EN  = 1'b1,
  parameter int unsigned CONST_VAL = DEF_CONST_VAL
) (
  input logic           clk,
  input logic           rst_n,
  mux_tree_pipe_if.slave bus
);

  localparam int unsigned SEL_W  = clog2(NUM_IN);
  localparam int unsigned LEVELS = SEL_W;

  if (!is_pow2(NUM_IN)) begin : g_bad_num_in
    $error("mux_tree_pipe: NUM_IN must be a power of two and at least 2");
  end

  // Levels 1..LEVELS packed back to back: level j starts at candidate NUM_IN - 2*(NUM_IN>>j)
  logic [(NUM_IN-1)*WIDTH-1:0] lvl_data;
  logic [LEVELS*SEL_W-1:0]     lvl_sel;
  logic [LEVELS*SEL_W-1:0]     lvl_orig;
  logic [LEVELS:1]             lvl_valid;
  logic [LEVELS:0]             ready_c;
  logic [NUM_IN*WIDTH-1:0]     in_vec_c;
  logic                        unused_sel_tail;

  // Input vector with the last channel optionally replaced by the constant
  always_comb begin
    in_vec_c = bus.in_data;
    if (CONST_EN) begin
      in_vec_c[(NUM_IN-1)*WIDTH +: WIDTH] = WIDTH'(CONST_VAL);
    end
  end

  // Ready chain from the consumer back to the input: a stage loads when empty or draining
  always_comb begin
    ready_c         = '0;
    ready_c[LEVELS] = bus.out_ready;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      ready_c[LEVELS-1-k] = !lvl_valid[LEVELS-k] || ready_c[LEVELS-k];
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NI     = NUM_IN >> k;
    localparam int unsigned OFF_IN = NUM_IN - 2 * (NUM_IN >> k);
    localparam int unsigned OFF_O  = NUM_IN - 2 * (NUM_IN >> (k + 1));

    logic [NI*WIDTH-1:0] st_data;
    logic [SEL_W-1:0]    st_sel;
    logic [SEL_W-1:0]    st_orig;
    logic                st_valid;

    if (k == 0) begin : g_src_in
      assign st_data  = in_vec_c;
      assign st_sel   = bus.in_sel;
      assign st_orig  = bus.in_sel;
      assign st_valid = bus.in_valid;
    end else begin : g_src_lvl
      assign st_data  = lvl_data[OFF_IN*WIDTH +: NI*WIDTH];
      assign st_sel   = lvl_sel[(k-1)*SEL_W +: SEL_W];
      assign st_orig  = lvl_orig[(k-1)*SEL_W +: SEL_W];
      assign st_valid = lvl_valid[k];
    end

    mux_tree_stage #(
      .WIDTH       (WIDTH),
      .N_IN        (NI),
      .SEL_W       (SEL_W),
      .RST_PAYLOAD (k == LEVELS - 1)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data_i   (st_data),
      .in_sel_i    (st_sel),
      .in_orig_i   (st_orig),
      .in_valid_i  (st_valid),
      .load_ok_i   (ready_c[k]),
      .out_data_o  (lvl_data[OFF_O*WIDTH +: (NI/2)*WIDTH]),
      .out_sel_o   (lvl_sel[k*SEL_W +: SEL_W]),
      .out_orig_o  (lvl_orig[k*SEL_W +: SEL_W]),
      .out_valid_o (lvl_valid[k+1])
    );
  end

  // Remaining-select bits after the last level are always zero
  assign unused_sel_tail = ^lvl_sel[(LEVELS-1)*SEL_W +: SEL_W];

  assign bus.in_ready  = ready_c[0];
  assign bus.out_data  = lvl_data[(NUM_IN-2)*WIDTH +: WIDTH];
  assign bus.out_sel   = lvl_orig[(LEVELS-1)*SEL_W +: SEL_W];
  assign bus.out_valid = lvl_valid[LEVELS];

endmodule
